// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and defaults for the memory port arbiter.
package mem_arb_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam logic [0:0] OWN_CPU = 1'b0;
  localparam logic [0:0] OWN_DMA = 1'b1;
  localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational 2-way round-robin picker; on a tie the requester that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  assign gnt_valid = |req;
  assign gnt_id = &req ? ~last : req[1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory port between CPU and DMA with round-robin fairness.
// Optional ack timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_adr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_done,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_adr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);
  logic state, owner, last, gnt_valid, gnt_id, tout, fin;
  rr_arb2 u_rr (
    .req      ({dma_req, cpu_req}),
    .last     (last),
    .gnt_valid(gnt_valid),
    .gnt_id   (gnt_id)
  );
`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt;
  // held at zero while idle, so it starts from zero in the first BUSY cycle
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (state == ST_IDLE) ? 8'd0 : cnt + 8'd1;
  assign tout = !mem_ack && cnt == TO_LAST;
`else
  assign tout = 1'b0;
`endif
  assign fin = state == ST_BUSY && (mem_ack || tout);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_CPU;
      last      <= OWN_DMA;
      cpu_done  <= 1'b0;
      dma_done  <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_adr   <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_done <= fin && owner == OWN_CPU;
      dma_done <= fin && owner == OWN_DMA;
      err      <= fin && !mem_ack;
      if (fin) begin
        rdata   <= (mem_ack && !mem_we) ? mem_rdata : '0;
        mem_req <= 1'b0;
        state   <= ST_IDLE;
      end else if (state == ST_IDLE && gnt_valid) begin
        owner     <= gnt_id;
        last      <= gnt_id;
        mem_we    <= gnt_id ? dma_we : cpu_we;
        mem_adr   <= gnt_id ? dma_adr : cpu_adr;
        mem_wdata <= gnt_id ? dma_wdata : cpu_wdata;
        mem_req   <= 1'b1;
        state     <= ST_BUSY;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a behavioural model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32;
  logic clk = 0, reset = 0;
  logic cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0, mem_ack = 0;
  logic [AW-1:0] cpu_adr = 0, dma_adr = 0;
  logic [DW-1:0] cpu_wdata = 0, dma_wdata = 0, mem_rdata = 0;
  logic cpu_done, dma_done, err, mem_req, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_adr;
  int checks = 0, failures = 0;
  int ack_lat = 0, busy_cnt = 0;
  bit stray = 0;
  logic [DW-1:0] rd_val = 0;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_done(cpu_done),
    .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata), .dma_done(dma_done),
    .rdata(rdata), .err(err), .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory model: acks ack_lat cycles after mem_req rises (never if negative); stray acks while idle
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack = ack_lat >= 0 && busy_cnt == ack_lat;
      mem_rdata = mem_ack ? rd_val : DW'($urandom);
      busy_cnt++;
    end else begin
      mem_ack = stray && $urandom_range(0, 1) == 1;
      mem_rdata = DW'($urandom);
      busy_cnt = 0;
    end
  end

  task automatic do_reset();
    cpu_req = 0;
    dma_req = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) begin
      checks++;
      if ({mem_req, mem_we, cpu_done, dma_done, err} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl: got %b want 00000", {mem_req, mem_we, cpu_done, dma_done, err});
      end
      @(negedge clk);
    end
    checks++;
    if (mem_adr !== 0 || mem_wdata !== 0 || rdata !== 0) begin
      failures++;
      $display("FAIL reset_data: adr=%h wdata=%h rdata=%h want 0", mem_adr, mem_wdata, rdata);
    end
  endtask

  task automatic test_single_cpu_read();
    int hi = 0, dn = 0, dd = 0;
    bit bad = 0;
    ack_lat = 3;
    rd_val = 32'hDEADBEEF;
    cpu_we = 0;
    cpu_adr = 32'h40;
    cpu_wdata = $urandom;
    cpu_req = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) begin
        hi++;
        if (mem_adr !== 32'h40 || mem_we !== 1'b0) bad = 1;
      end
      if (dma_done) dd++;
      if (cpu_done) begin
        dn++;
        cpu_req = 0;
        checks++;
        if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
          failures++;
          $display("FAIL single_read_data: rdata=%h err=%b want deadbeef/0", rdata, err);
        end
      end
    end
    checks++;
    if (bad) begin failures++; $display("FAIL single_read_stable: mem_adr/mem_we changed, want 40/0"); end
    checks++;
    if (hi != 4) begin failures++; $display("FAIL single_read_busy: mem_req high %0d cycles want 4", hi); end
    checks++;
    if (dn != 1 || dd != 0) begin
      failures++;
      $display("FAIL single_read_done: cpu_done=%0d dma_done=%0d want 1/0", dn, dd);
    end
  endtask

  task automatic test_tie();
    bit exp_own[4] = '{0, 1, 0, 1};
    int n = 0, low = 0;
    bit prev = 0;
    do_reset();
    ack_lat = $urandom_range(0, 3);
    rd_val = $urandom;
    cpu_we = 0; dma_we = 0;
    cpu_adr = 32'h1000; dma_adr = 32'h2000;
    cpu_req = 1; dma_req = 1;
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        if (n > 0) begin
          checks++;
          if (low != 1) begin failures++; $display("FAIL tie_gap: idle %0d cycles want 1", low); end
        end
        checks++;
        if (mem_adr !== (exp_own[n] ? 32'h2000 : 32'h1000)) begin
          failures++;
          $display("FAIL tie_grant_adr: got %h want %h", mem_adr, exp_own[n] ? 32'h2000 : 32'h1000);
        end
        low = 0;
      end
      if (!mem_req) low++;
      prev = mem_req;
      if (cpu_done || dma_done) begin
        checks++;
        if ((cpu_done && dma_done) || dma_done !== exp_own[n]) begin
          failures++;
          $display("FAIL tie_order: done cpu=%b dma=%b want owner %0d", cpu_done, dma_done, exp_own[n]);
        end
        n++;
        ack_lat = $urandom_range(0, 3);
        rd_val = $urandom;
        if (n == 4) begin cpu_req = 0; dma_req = 0; end
      end
    end
    checks++;
    if (n != 4) begin failures++; $display("FAIL tie_count: %0d completions want 4", n); end
    @(negedge clk);
  endtask

  task automatic test_dma_write();
    int at = -1;
    ack_lat = 0;
    dma_we = 1;
    dma_adr = 32'h100;
    dma_wdata = 32'h12345678;
    dma_req = 1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++;
        if (mem_req !== 1 || mem_we !== 1 || mem_wdata !== 32'h12345678 || mem_adr !== 32'h100) begin
          failures++;
          $display("FAIL dma_write_mem: req=%b we=%b adr=%h wdata=%h want 1/1/100/12345678",
                   mem_req, mem_we, mem_adr, mem_wdata);
        end
      end
      if (dma_done && at < 0) begin
        at = c;
        dma_req = 0;
        checks++;
        if (rdata !== 0 || err !== 0) begin
          failures++;
          $display("FAIL dma_write_done: rdata=%h err=%b want 0/0", rdata, err);
        end
      end
    end
    checks++;
    if (at != 2) begin failures++; $display("FAIL dma_write_latency: done at %0d want 2", at); end
    dma_we = 0;
  endtask

  task automatic test_reset_mid();
    int dn = 0;
    ack_lat = -1;
    cpu_we = 0;
    cpu_adr = 32'h80;
    cpu_req = 1;
    for (int c = 0; c < 5 && !mem_req; c++) @(negedge clk);
    @(negedge clk);
    #2 reset = 0;
    #1;
    checks++;
    if ({mem_req, mem_we, cpu_done, dma_done, err} !== 5'b0 || mem_adr !== 0 || rdata !== 0 || mem_wdata !== 0) begin
      failures++;
      $display("FAIL reset_mid_async: req=%b adr=%h rdata=%h want all 0", mem_req, mem_adr, rdata);
    end
    cpu_req = 0;
    @(negedge clk);
    reset = 1;
    ack_lat = 1;
    rd_val = 32'hCAFEF00D;
    cpu_adr = 32'h84;
    cpu_req = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_done) begin
        dn++;
        cpu_req = 0;
        checks++;
        if (rdata !== 32'hCAFEF00D || err !== 0) begin
          failures++;
          $display("FAIL reset_mid_recover: rdata=%h err=%b want cafef00d/0", rdata, err);
        end
      end
    end
    checks++;
    if (dn != 1) begin failures++; $display("FAIL reset_mid_done: %0d pulses want 1", dn); end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int k = 0; k < 2; k++) begin
      int hi = 0, dn = 0;
      ack_lat = k == 0 ? -1 : 3;
      rd_val = $urandom | 32'h1;
      cpu_we = 0;
      cpu_adr = 32'h200;
      cpu_req = 1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (mem_req) hi++;
        if (cpu_done) begin
          dn++;
          cpu_req = 0;
          checks++;
          if (err !== (k == 0) || rdata !== (k == 0 ? 32'h0 : rd_val)) begin
            failures++;
            $display("FAIL timeout_done%0d: err=%b rdata=%h want %0d/%h", k, err, rdata, k == 0, k == 0 ? 32'h0 : rd_val);
          end
        end
      end
      checks++;
      if (hi != 4 || dn != 1) begin
        failures++;
        $display("FAIL timeout_len%0d: mem_req %0d cycles, %0d dones want 4/1", k, hi, dn);
      end
    end
  endtask
`endif

  task automatic test_drop();
    int dd = 0, dc = -100, gc = -1;
    ack_lat = 2;
    rd_val = 32'h55AA55AA;
    dma_we = 0;
    dma_adr = 32'h300;
    dma_req = 1;
    for (int c = 0; c < 5 && !mem_req; c++) @(negedge clk);
    dma_req = 0;
    cpu_we = 0;
    cpu_adr = 32'h400;
    cpu_req = 1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (dma_done) begin
        dd++;
        dc = c;
        checks++;
        if (rdata !== 32'h55AA55AA) begin failures++; $display("FAIL drop_rdata: got %h want 55aa55aa", rdata); end
      end
      if (mem_req && mem_adr === 32'h400 && gc < 0) gc = c;
      if (cpu_done) cpu_req = 0;
    end
    checks++;
    if (dd != 1) begin failures++; $display("FAIL drop_done: %0d pulses want 1", dd); end
    checks++;
    if (gc != dc + 1) begin failures++; $display("FAIL drop_next_grant: cycle %0d want %0d", gc, dc + 1); end
  endtask

  // reference: requests seen at a grant pick the one not granted last on a tie; reads return the memory word
  task automatic test_random();
    int left[2], wait_c[2], dones = 0;
    logic t_we[2];
    logic [AW-1:0] t_adr[2];
    logic [DW-1:0] t_wd[2], exp_rd;
    bit last = 1, own = 0, prev = 0;
    do_reset();
    stray = 1;
    ack_lat = $urandom_range(0, 3);
    rd_val = $urandom;
    for (int i = 0; i < 2; i++) begin
      left[i] = $urandom_range(3, 8);
      wait_c[i] = $urandom_range(0, 3);
    end
    for (int c = 0; c < 3000 && (left[0] + left[1]) > 0; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        own = (cpu_req && dma_req) ? !last : dma_req;
        last = own;
        exp_rd = t_we[own] ? '0 : rd_val;
        checks++;
        if (mem_adr !== t_adr[own] || mem_we !== t_we[own] || mem_wdata !== t_wd[own]) begin
          failures++;
          $display("FAIL rand_grant: adr=%h we=%b wdata=%h want %h/%b/%h owner %0d",
                   mem_adr, mem_we, mem_wdata, t_adr[own], t_we[own], t_wd[own], own);
        end
      end
      prev = mem_req;
      if (cpu_done || dma_done) begin
        dones++;
        checks++;
        if ((cpu_done && dma_done) || dma_done !== own || rdata !== exp_rd || err !== 0) begin
          failures++;
          $display("FAIL rand_done: cpu=%b dma=%b rdata=%h err=%b want owner %0d rdata %h",
                   cpu_done, dma_done, rdata, err, own, exp_rd);
        end
        left[own]--;
        ack_lat = $urandom_range(0, 3);
        rd_val = $urandom;
        if (left[own] > 0 && $urandom_range(0, 1) == 1) wait_c[own] = 0;
        else begin
          wait_c[own] = $urandom_range(1, 3);
          if (own) dma_req = 0; else cpu_req = 0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (left[i] > 0 && wait_c[i] == 0 && !(i == own && (cpu_done || dma_done) ? 0 : (i ? dma_req : cpu_req))) begin
          t_we[i] = $urandom_range(0, 1);
          t_adr[i] = $urandom;
          t_wd[i] = $urandom;
          if (i == 1) begin dma_req = 1; dma_we = t_we[1]; dma_adr = t_adr[1]; dma_wdata = t_wd[1]; end
          else begin cpu_req = 1; cpu_we = t_we[0]; cpu_adr = t_adr[0]; cpu_wdata = t_wd[0]; end
          wait_c[i] = -1;
        end else if (wait_c[i] > 0 && !(i ? dma_req : cpu_req)) wait_c[i]--;
      end
    end
    checks++;
    if (left[0] != 0 || left[1] != 0) begin
      failures++;
      $display("FAIL rand_complete: left cpu=%0d dma=%0d want 0/0 after %0d dones", left[0], left[1], dones);
    end
    stray = 0;
    cpu_req = 0;
    dma_req = 0;
  endtask

  initial begin
    test_reset();
    test_single_cpu_read();
    test_tie();
    test_dma_write();
    test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
